// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response handshake for the data-memory access controller.
// The CPU is the master; the controller is the slave.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata, req_pc, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator for the word-wide data memory: sub-word loads with extension and sub-word
// stores via read-modify-write, one request in flight, valid/ready on both sides.
module mem_access_ctrl #(
  parameter int unsigned DM_BYTES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_ctrl_if.slave   bus,
  output logic [31:0]        mem_PC,
  output logic [31:0]        mem_A,
  output logic [31:0]        mem_WD,
  output logic               mem_WE,
  input  logic [31:0]        mem_RD
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  localparam logic [2:0] TypeW  = 3'b000;
  localparam logic [2:0] TypeH  = 3'b001;
  localparam logic [2:0] TypeHu = 3'b010;
  localparam logic [2:0] TypeB  = 3'b011;
  localparam logic [2:0] TypeBu = 3'b100;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [2:0]  type_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_illegal;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_err;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] store_word;

  // Request legality, evaluated on the live request so the decision is made at accept.
  always_comb begin
    req_illegal = (bus.req_type > TypeBu) ||
                  (bus.req_we && ((bus.req_type == TypeHu) || (bus.req_type == TypeBu)));
    req_misaligned = (((bus.req_type == TypeH) || (bus.req_type == TypeHu)) && bus.req_addr[0]) ||
                     ((bus.req_type == TypeW) && (bus.req_addr[1:0] != 2'b00));
    req_out_of_range = (bus.req_addr >= 32'(DM_BYTES));
    req_err = req_illegal || req_misaligned || req_out_of_range;
  end

  // Little-endian lane extraction straight from the memory read port.
  always_comb begin
    load_byte = mem_RD[7:0];
    unique case (addr_q[1:0])
      2'd0: load_byte = mem_RD[7:0];
      2'd1: load_byte = mem_RD[15:8];
      2'd2: load_byte = mem_RD[23:16];
      2'd3: load_byte = mem_RD[31:24];
      default: load_byte = mem_RD[7:0];
    endcase
    load_half = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    case (type_q)
      TypeH:   load_data = {{16{load_half[15]}}, load_half};
      TypeHu:  load_data = {16'h0000, load_half};
      TypeB:   load_data = {{24{load_byte[7]}}, load_byte};
      TypeBu:  load_data = {24'h000000, load_byte};
      default: load_data = mem_RD;
    endcase
  end

  // Merge the store data into the captured word; only the addressed lane changes.
  always_comb begin
    store_word = word_q;
    case (type_q)
      TypeW: store_word = wdata_q;
      TypeH: begin
        if (addr_q[1]) store_word[31:16] = wdata_q[15:0];
        else           store_word[15:0]  = wdata_q[15:0];
      end
      TypeB: begin
        unique case (addr_q[1:0])
          2'd0: store_word[7:0]   = wdata_q[7:0];
          2'd1: store_word[15:8]  = wdata_q[7:0];
          2'd2: store_word[23:16] = wdata_q[7:0];
          2'd3: store_word[31:24] = wdata_q[7:0];
          default: store_word = word_q;
        endcase
      end
      default: store_word = word_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      type_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      pc_q    <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            type_q  <= bus.req_type;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
            pc_q    <= bus.req_pc;
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err) begin
              state_q <= StResp;
            end else if (bus.req_we && (bus.req_type == TypeW)) begin
              state_q <= StWrite;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          word_q <= mem_RD;
          if (we_q) begin
            state_q <= StWrite;
          end else begin
            rdata_q <= load_data;
            state_q <= StResp;
          end
        end
        StWrite: begin
          state_q <= StResp;
        end
        StResp: begin
          if (bus.resp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = (state_q == StResp);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    mem_PC         = pc_q;
    mem_A          = {addr_q[31:2], 2'b00};
    mem_WD         = store_word;
    // A reset cycle must never commit a write, even mid-WRITE.
    mem_WE         = (state_q == StWrite) && !reset;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: word-memory model, scoreboard of expected responses, immediate assertions.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_PC;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.DM_BYTES(4096)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .mem_PC (mem_PC),
    .mem_A  (mem_A),
    .mem_WD (mem_WD),
    .mem_WE (mem_WE),
    .mem_RD (mem_RD)
  );

  always #5 clk = ~clk;

  logic [31:0] dm [0:1023];
  int wr_count = 0;
  assign mem_RD = dm[mem_A[11:2]];
  always @(posedge clk) begin
    if (mem_WE) begin
      dm[mem_A[11:2]] <= mem_WD;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    logic [31:0] a;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] pc_ctr = 32'h0000_0400;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; hold = cycles the response is back-pressured before acceptance.
  task automatic do_req(input string tag, input logic we, input logic [2:0] typ,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_wr, input int hold);
    exp_t e;
    int lat;
    int wc0;
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    pc_ctr = pc_ctr + 32'd4;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_type   = typ;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_pc     = pc_ctr;
    bus.resp_ready = (hold == 0);
    e.rdata = exp_rdata;
    e.err = exp_err;
    e.lat = exp_lat;
    e.writes = exp_wr;
    e.a = {addr[31:2], 2'b00};
    e.pc = pc_ctr;
    sb.push_back(e);
    wc0 = wr_count;
    @(posedge clk); #1;
    // Garbage on the request bus must be ignored while busy.
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_pc    = $urandom;
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({tag, " rdata"}, bus.resp_rdata, e.rdata);
    chk({tag, " err"}, 32'(bus.resp_err), 32'(e.err));
    chk({tag, " mem_A"}, mem_A, e.a);
    chk({tag, " mem_PC"}, mem_PC, e.pc);
    chk({tag, " busy"}, 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " held valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, " held rdata"}, bus.resp_rdata, e.rdata);
      chk({tag, " held busy"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " resp done"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, " writes"}, 32'(wr_count - wc0), 32'(e.writes));
  endtask

  initial begin
    int wc0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_type   = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_pc     = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_WE", 32'(mem_WE), 32'd0);
    reset = 1'b0;
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst mem_A", mem_A, 32'd0);
    chk("rst mem_PC", mem_PC, 32'd0);

    // Word store then load back
    do_req("SW 10", 1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0);
    chk("SW 10 dm", dm[4], 32'hDEADBEEF);
    do_req("LW 10", 1'b0, 3'b000, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 0);

    // Sub-word read-modify-write
    do_req("SW 10b", 1'b1, 3'b000, 32'h10, 32'h11223344, 32'h0, 1'b0, 2, 1, 0);
    do_req("SB 12", 1'b1, 3'b011, 32'h12, 32'h000000AA, 32'h0, 1'b0, 3, 1, 0);
    chk("SB 12 dm", dm[4], 32'h11AA3344);
    do_req("SH 10", 1'b1, 3'b001, 32'h10, 32'h00005566, 32'h0, 1'b0, 3, 1, 0);
    chk("SH 10 dm", dm[4], 32'h11AA5566);
    do_req("SB 13", 1'b1, 3'b011, 32'h13, 32'hFFFFFF77, 32'h0, 1'b0, 3, 1, 0);
    do_req("LW 10c", 1'b0, 3'b000, 32'h10, 32'h0, 32'h77AA5566, 1'b0, 2, 0, 0);

    // Extension on every lane
    do_req("SW 20", 1'b1, 3'b000, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, 2, 1, 0);
    do_req("LB 21", 1'b0, 3'b011, 32'h21, 32'h0, 32'h0000007F, 1'b0, 2, 0, 0);
    do_req("LB 22", 1'b0, 3'b011, 32'h22, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0, 0);
    do_req("LBU 23", 1'b0, 3'b100, 32'h23, 32'h0, 32'h00000080, 1'b0, 2, 0, 0);
    do_req("LB 23", 1'b0, 3'b011, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 0);
    do_req("LBU 20", 1'b0, 3'b100, 32'h20, 32'h0, 32'h00000001, 1'b0, 2, 0, 0);
    do_req("LH 22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0, 0);
    do_req("LHU 22", 1'b0, 3'b010, 32'h22, 32'h0, 32'h000080FF, 1'b0, 2, 0, 0);
    do_req("LH 20", 1'b0, 3'b001, 32'h20, 32'h0, 32'h00007F01, 1'b0, 2, 0, 0);

    // Top of memory is legal
    do_req("SW FFC", 1'b1, 3'b000, 32'hFFC, 32'h12345678, 32'h0, 1'b0, 2, 1, 0);
    do_req("LW FFC", 1'b0, 3'b000, 32'hFFC, 32'h0, 32'h12345678, 1'b0, 2, 0, 0);

    // Errors: one-cycle latency, no writes
    do_req("LW 12 err", 1'b0, 3'b000, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("SH 13 err", 1'b1, 3'b001, 32'h13, 32'h1234, 32'h0, 1'b1, 1, 0, 0);
    do_req("LW 1000 err", 1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("type 7 err", 1'b0, 3'b111, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("SHU err", 1'b1, 3'b010, 32'h20, 32'h1234, 32'h0, 1'b1, 1, 0, 0);
    do_req("SBU err", 1'b1, 3'b100, 32'h20, 32'h12, 32'h0, 1'b1, 1, 0, 0);
    chk("err dm intact", dm[8], 32'h80FF7F01);

    // Response backpressure
    do_req("LW bp", 1'b0, 3'b000, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 2, 0, 5);

    // Reset during the WRITE cycle of a byte store
    do_req("SW 30", 1'b1, 3'b000, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 0);
    wc0 = wr_count;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_type  = 3'b011;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h55;
    bus.req_pc    = 32'h900;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw pre WE", 32'(mem_WE), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw WE", 32'(mem_WE), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstw req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstw mem_A", mem_A, 32'd0);
    chk("rstw writes", 32'(wr_count - wc0), 32'd0);
    chk("rstw dm", dm[12], 32'hCAFEF00D);
    do_req("LW 30", 1'b0, 3'b000, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
